usr_write_arbiter: RTL and testbench
====================================

USR_WRITE_ARBITER -- requirements
Module: usr_write_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, the ownership cycle limit before forced release (range 2..255).
REQ-002 SHALL have parameter PARK_ID, default 2'h0, the usr_id value driven whenever no write is in flight.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, 4 bits: req[i] high while requester i wants ownership.
REQ-006 SHALL have port wr_en, input, 4 bits: wr_en[i] is a write strobe from requester i.
REQ-007 SHALL have port wr_data, input, 32 bits: byte i (bits 8i+7..8i) is requester i's data.
REQ-008 SHALL have port gnt, output, 4 bits: one-hot or zero ownership grant.
REQ-009 SHALL have port usr_id, output, 2 bits: ID presented to the downstream user-locked register.
REQ-010 SHALL have port data_in, output, 8 bits: data presented to the downstream register.
REQ-011 SHALL have port viol_cnt, output, 8 bits: saturating count of rejected writes.
REQ-012 SHALL have port revoked, output, 1 bit: sticky flag, set on a forced release.

Function
REQ-013 SHALL implement FSM states IDLE, OWN and TURN; all outputs registered.
REQ-014 IDLE: if any req is high, SHALL grant via round-robin starting at (last_owner+1) mod 4 and enter OWN; gnt is visible the next cycle.
REQ-015 OWN: when req[owner] is low, SHALL clear gnt and enter TURN.
REQ-016 TURN: SHALL last exactly one cycle with gnt=0 and usr_id=PARK_ID, then enter IDLE; no back-to-back grants.
REQ-017 In OWN, for a cycle with wr_en[owner]=1, SHALL drive usr_id=owner and data_in=wr_data byte owner on the next cycle (1-cycle latency).
REQ-018 In all other cycles, SHALL drive usr_id=PARK_ID and hold data_in at its last value.
REQ-019 SHALL count, per cycle, one violation if any wr_en[i] is high where i is not the current owner, or where the FSM is not in OWN; viol_cnt saturates at 255.
REQ-020 A simultaneous valid owner write and non-owner write SHALL forward the owner write and count one violation.
REQ-021 Round-robin pointer last_owner SHALL update on each grant; reset value 2'd3, so requester 0 wins first.
REQ-022 Requests raised during OWN or TURN SHALL be held off until IDLE; req drop by a non-owner has no effect.

Reset
REQ-023 On rst_n low, SHALL asynchronously force: state=IDLE, gnt=0, usr_id=PARK_ID, data_in=0, viol_cnt=0, revoked=0, hold counter=0, last_owner=3.
REQ-024 Reset mid-ownership SHALL drop gnt immediately; no pending write is forwarded after reset release.
REQ-025 First grant after reset release SHALL require req sampled high at a clk edge with rst_n high.

Configuration
REQ-026 Macro USR_ARB_TIMEOUT_EN: when defined, an 8-bit hold counter SHALL count OWN cycles, and on reaching MAX_HOLD SHALL force OWN->TURN, set revoked, and discard any owner write in that cycle (counted as a violation).
REQ-027 Without USR_ARB_TIMEOUT_EN, ownership SHALL persist until req[owner] drops, and revoked SHALL be tied to 0.

Verification
REQ-028 Reset, then req=4'b0100 -> gnt=4'b0100 one cycle later; wr_en[2]=1, wr_data byte2=8'hA5 -> next cycle usr_id=2'h2, data_in=8'hA5; following cycle usr_id=PARK_ID.
REQ-029 Owner 2, wr_en=4'b0010 -> usr_id stays PARK_ID; viol_cnt increments 0->1.
REQ-030 req=4'b1111 held, each owner drops req after 3 cycles -> grant order 0,1,2,3,0, each separated by a 1-cycle TURN with gnt=0.
REQ-031 With USR_ARB_TIMEOUT_EN, MAX_HOLD=4, req[1] held high -> gnt[1] drops after 4 OWN cycles, revoked=1 and stays 1 until reset.
REQ-032 260 non-owner write cycles -> viol_cnt=255, no wrap.
REQ-033 rst_n pulsed low while owner 3 writes 8'h3C -> gnt=0, data_in=0 and usr_id=PARK_ID immediately; 8'h3C is never presented.

Source files
------------

// File: rtl/usr_write_arbiter.sv
// Round-robin write arbiter that owns access to a user-locked register for one requester at a time.
// Optional forced release after MAX_HOLD owner cycles is enabled by defining USR_ARB_TIMEOUT_EN.
module usr_write_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter logic [1:0]  PARK_ID  = 2'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [3:0]  wr_en,
    input  logic [31:0] wr_data,
    output logic [3:0]  gnt,
    output logic [1:0]  usr_id,
    output logic [7:0]  data_in,
    output logic [7:0]  viol_cnt,
    output logic        revoked
);

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned VIOL_W   = 8;
    localparam logic [VIOL_W-1:0] VIOL_MAX = 8'hFF;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("usr_write_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [1:0]          usr_id_q, usr_id_d;
    logic [7:0]          data_q, data_d;
    logic [VIOL_W-1:0]   viol_q, viol_d;
    logic [1:0]          last_q, last_d;
    logic [1:0]          pick_c;
    logic [1:0]          cand_c;
    logic                found_c;
    logic                viol_hit_c;
    logic                timeout_c;
    logic [N_REQ-1:0]    owner_oh_c;

`ifdef USR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
    logic       revoked_q, revoked_d;
`endif

    // Round-robin search starting just after the previous owner
    always_comb begin
        pick_c  = last_q;
        cand_c  = last_q;
        found_c = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand_c = last_q + 2'(k);
            if (!found_c && req[cand_c]) begin
                pick_c  = cand_c;
                found_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        usr_id_d   = PARK_ID;
        data_d     = data_q;
        last_d     = last_q;
        viol_hit_c = 1'b0;
        owner_oh_c = 4'b0001 << last_q;
`ifdef USR_ARB_TIMEOUT_EN
        timeout_c  = (state_q == OWN) && (hold_q == HOLD_LAST);
        hold_d     = (state_q == OWN) ? hold_q + 8'd1 : 8'd0;
        revoked_d  = revoked_q | timeout_c;
`else
        timeout_c  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                viol_hit_c = |wr_en;
                if (|req) begin
                    state_d = OWN;
                    gnt_d   = 4'b0001 << pick_c;
                    last_d  = pick_c;
                end
            end
            OWN: begin
                viol_hit_c = |(wr_en & ~owner_oh_c);
                if (timeout_c) begin
                    // Forced release: the owner's write this cycle is discarded and counted
                    state_d    = TURN;
                    gnt_d      = '0;
                    viol_hit_c = viol_hit_c | wr_en[last_q];
                end else begin
                    if (wr_en[last_q]) begin
                        usr_id_d = last_q;
                        data_d   = wr_data[{last_q, 3'b000} +: 8];
                    end
                    if (!req[last_q]) begin
                        state_d = TURN;
                        gnt_d   = '0;
                    end
                end
            end
            TURN: begin
                viol_hit_c = |wr_en;
                state_d    = IDLE;
                gnt_d      = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        viol_d = (viol_hit_c && (viol_q != VIOL_MAX)) ? viol_q + 8'd1 : viol_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            usr_id_q <= PARK_ID;
            data_q   <= '0;
            viol_q   <= '0;
            last_q   <= 2'd3;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            usr_id_q <= usr_id_d;
            data_q   <= data_d;
            viol_q   <= viol_d;
            last_q   <= last_d;
        end
    end

`ifdef USR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            revoked_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            revoked_q <= revoked_d;
        end
    end
    assign revoked = revoked_q;
`else
    assign revoked = 1'b0;
`endif

    assign gnt      = gnt_q;
    assign usr_id   = usr_id_q;
    assign data_in  = data_q;
    assign viol_cnt = viol_q;

endmodule

// File: tb/tb_usr_write_arbiter.sv
// Scoreboard bench for usr_write_arbiter: a cycle-level reference model queues expected outputs,
// a monitor pops and compares them one time unit after each rising edge.
module tb_usr_write_arbiter;

    localparam int unsigned MAX_HOLD = 4;
    localparam logic [1:0]  PARK     = 2'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  wr_en;
    logic [31:0] wr_data;
    logic [3:0]  gnt;
    logic [1:0]  usr_id;
    logic [7:0]  data_in;
    logic [7:0]  viol_cnt;
    logic        revoked;

    usr_write_arbiter #(.MAX_HOLD(MAX_HOLD), .PARK_ID(PARK)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr_en(wr_en), .wr_data(wr_data),
        .gnt(gnt), .usr_id(usr_id), .data_in(data_in), .viol_cnt(viol_cnt), .revoked(revoked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] uid;
        logic [7:0] data;
        logic [7:0] viol;
        logic       rev;
    } exp_t;

    exp_t sb[$];
    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: phase 0 = nobody owns, 1 = owned, 2 = mandatory gap cycle
    int         m_phase, m_owner, m_last, m_viol, m_hold;
    bit         m_rev;
    logic [3:0] m_gnt;
    logic [1:0] m_uid;
    logic [7:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_phase = 0; m_owner = 3; m_last = 3; m_viol = 0; m_hold = 0; m_rev = 0;
        m_gnt = 4'h0; m_uid = PARK; m_data = 8'h00;
    endfunction

    function automatic void model_step(input logic [3:0] rq, input logic [3:0] we, input logic [31:0] wd);
        bit bad = 0;
        bit fwd = 0;
        bit to  = 0;
        int nphase = m_phase;
        if (m_phase == 0) begin
            if (we != 0) bad = 1;
            if (rq != 0) begin
                bit found = 0;
                for (int k = 1; k <= 4; k++) begin
                    int c = (m_last + k) % 4;
                    if (!found && rq[c]) begin m_owner = c; found = 1; end
                end
                m_last = m_owner; m_hold = 0; nphase = 1;
            end
        end else if (m_phase == 1) begin
            if ((we & ~(4'b0001 << m_owner)) != 0) bad = 1;
`ifdef USR_ARB_TIMEOUT_EN
            m_hold++;
            if (m_hold == MAX_HOLD) to = 1;
`endif
            if (to) begin
                if (we[m_owner]) bad = 1;
                m_rev = 1; nphase = 2;
            end else begin
                if (we[m_owner]) fwd = 1;
                if (!rq[m_owner]) nphase = 2;
            end
        end else begin
            if (we != 0) bad = 1;
            nphase = 0;
        end
        if (bad && m_viol < 255) m_viol++;
        m_phase = nphase;
        m_gnt   = (nphase == 1) ? (4'b0001 << m_owner) : 4'h0;
        m_uid   = fwd ? 2'(m_owner) : PARK;
        if (fwd) m_data = wd[8*m_owner +: 8];
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.gnt = m_gnt; e.uid = m_uid; e.data = m_data; e.viol = 8'(m_viol); e.rev = m_rev;
        sb.push_back(e);
    endfunction

    // Monitor: registered outputs are presented every cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("mon_gnt", 32'(gnt), 32'(e.gnt));
                chk("mon_usr_id", 32'(usr_id), 32'(e.uid));
                chk("mon_data_in", 32'(data_in), 32'(e.data));
                chk("mon_viol_cnt", 32'(viol_cnt), 32'(e.viol));
                chk("mon_revoked", 32'(revoked), 32'(e.rev));
            end
        end
    end

    task automatic cycle(input logic [3:0] rq, input logic [3:0] we, input logic [31:0] wd);
        @(negedge clk);
        rst_n = 1'b1; req = rq; wr_en = we; wr_data = wd;
        @(posedge clk);
        model_step(rq, we, wd);
        push_exp();
    endtask

    task automatic reset_pulse(input logic [3:0] rq, input logic [3:0] we, input logic [31:0] wd);
        @(negedge clk);
        req = rq; wr_en = we; wr_data = wd;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_gnt", 32'(gnt), 32'h0);
        chk("rst_async_usr_id", 32'(usr_id), 32'(PARK));
        chk("rst_async_data_in", 32'(data_in), 32'h0);
        @(posedge clk);
        model_reset();
        push_exp();
    endtask

    int         order[$];
    int         exp_ord[5] = '{0, 1, 2, 3, 0};
    logic [3:0] cur_gnt;
    int         held;
    int         run;
    bit         dropped;

    initial begin
        rst_n = 1'b0; req = '0; wr_en = '0; wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_usr_id", 32'(usr_id), 32'(PARK));
        chk("reset_data_in", 32'(data_in), 32'h0);
        chk("reset_viol_cnt", 32'(viol_cnt), 32'h0);
        chk("reset_revoked", 32'(revoked), 32'h0);

        // Single owner write forwarding and non-owner violation
        cycle(4'b0100, 4'b0000, 32'h0);
        #1 chk("grant_req2", 32'(gnt), 32'h4);
        cycle(4'b0100, 4'b0100, 32'h00A5_0000);
        #1 chk("fwd_usr_id", 32'(usr_id), 32'h2);
        chk("fwd_data_in", 32'(data_in), 32'hA5);
        cycle(4'b0100, 4'b0000, 32'h0);
        #1 chk("fwd_park_after", 32'(usr_id), 32'(PARK));
        cycle(4'b0100, 4'b0010, 32'h0000_7700);
        #1 chk("nonowner_usr_id", 32'(usr_id), 32'(PARK));
        chk("nonowner_viol", 32'(viol_cnt), 32'h1);
        chk("nonowner_data_hold", 32'(data_in), 32'hA5);

        // Rotation with all requesters active; each owner drops after 3 grant cycles
        reset_pulse(4'b0000, 4'b0000, 32'h0);
        cur_gnt = 4'h0; held = 0;
        for (int n = 0; n < 60 && order.size() < 5; n++) begin
            logic [3:0] rq;
            rq = 4'hF;
            if (cur_gnt != 0 && held >= 3) rq = rq & ~cur_gnt;
            cycle(rq, 4'b0000, 32'h0);
            #1;
            if (gnt != 0 && gnt != cur_gnt) begin
                for (int i = 0; i < 4; i++) if (gnt[i]) order.push_back(i);
                held = 1;
            end else if (gnt != 0) begin
                held++;
            end
            cur_gnt = gnt;
        end
        chk("rr_grant_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(exp_ord[i]));

        // Violation counter saturation
        repeat (3) cycle(4'b0000, 4'b0000, 32'h0);
        for (int n = 0; n < 260; n++) cycle(4'b0000, 4'($urandom_range(1, 15)), $urandom);
        #1 chk("viol_saturate", 32'(viol_cnt), 32'd255);

        // Long hold by requester 1
        reset_pulse(4'b0000, 4'b0000, 32'h0);
        run = 0; dropped = 0;
        for (int n = 0; n < 12; n++) begin
            cycle(4'b0010, 4'b0000, 32'h0);
            #1;
            if (gnt[1] && !dropped) run++;
            else if (run > 0) dropped = 1;
        end
`ifdef USR_ARB_TIMEOUT_EN
        chk("timeout_hold_len", 32'(run), 32'(MAX_HOLD));
        chk("timeout_revoked", 32'(revoked), 32'h1);
`else
        chk("persist_hold_len", 32'(run), 32'd12);
        chk("persist_revoked", 32'(revoked), 32'h0);
`endif

        // Reset while owner 3 is writing
        reset_pulse(4'b0000, 4'b0000, 32'h0);
        cycle(4'b1000, 4'b0000, 32'h0);
        cycle(4'b1000, 4'b0000, 32'h0);
        reset_pulse(4'b1000, 4'b1000, 32'h3C00_0000);
        for (int n = 0; n < 3; n++) begin
            cycle(4'b0000, 4'b0000, 32'h0);
            #1 chk("post_rst_data_in", 32'(data_in), 32'h0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [3:0] rq, we;
            rq = req;
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
            we = '0;
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) we[i] = 1'b1;
            if ($urandom_range(0, 149) == 0) reset_pulse(rq, we, $urandom);
            else cycle(rq, we, $urandom);
        end

        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
